enemy_attack_scheduler: RTL and testbench
=========================================

ENEMY_ATTACK_SCHEDULER -- requirements
Module: enemy_attack_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENEMY, default 4: number of requesting enemies (2..8).
REQ-002 SHALL have parameter SHOW_FRAMES, default 4: frame ticks the attack effect stays on.
REQ-003 SHALL have parameter COOLDOWN_FRAMES, default 8: frame ticks after the effect before the next grant.
REQ-004 SHALL have parameter DAMAGE, default 8'd10: HP removed per granted attack.
REQ-005 SHALL have parameter HP_INIT, default 8'd100: player HP after reset.
REQ-006 SHALL have port Clk, input, 1: system clock; the only clock.
REQ-007 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port frame_clk, input, 1: vertical-sync rate frame clock, sampled as data on Clk.
REQ-009 SHALL have port Attack_Req, input, NUM_ENEMY: bit i high = enemy i is in attack range of the player.
REQ-010 SHALL have port Attack_Grant, output, NUM_ENEMY: one-hot, one-cycle pulse naming the enemy whose attack lands.
REQ-011 SHALL have port Attack_Owner, output, 3: index of the most recent granted enemy.
REQ-012 SHALL have port Enemy_Attack_Ready, output, 1: high while the attack effect is displayed.
REQ-013 SHALL have port Player_HP, output, 8: current player hit points.
REQ-014 SHALL have port Player_Dead, output, 1: high when Player_HP == 0.

Function
REQ-015 SHALL derive tick: frame_clk registered once, then tick registered as (frame_clk & ~delayed); tick is high for exactly one Clk cycle per frame_clk rising edge.
REQ-016 SHALL implement FSM states IDLE, GRANT, SHOW, COOLDOWN.
REQ-017 IDLE: on tick with Attack_Req != 0 and Player_Dead == 0, SHALL latch the winner and go to GRANT on the next cycle; otherwise remain in IDLE.
REQ-018 Winner SHALL be the first set Attack_Req bit, searching upward from priority pointer ptr and wrapping from NUM_ENEMY-1 to 0.
REQ-019 GRANT lasts exactly one cycle: Attack_Grant[winner]=1, Attack_Owner<=winner, ptr<=(winner+1) mod NUM_ENEMY, Player_HP<=max(Player_HP-DAMAGE,0); the FSM then goes to SHOW.
REQ-020 SHOW: Enemy_Attack_Ready=1; SHALL count ticks and go to COOLDOWN on the SHOW_FRAMES-th tick.
REQ-021 COOLDOWN: Enemy_Attack_Ready=0; SHALL count ticks and go to IDLE on the COOLDOWN_FRAMES-th tick.
REQ-022 Attack_Req SHALL be ignored outside IDLE; a request that drops during SHOW/COOLDOWN SHALL NOT cancel the attack in progress.
REQ-023 Attack_Grant SHALL be all-zero in every state except GRANT.
REQ-024 HP subtraction SHALL saturate at 0 and never wrap; Player_Dead SHALL be combinational (Player_HP == 0).
REQ-025 With Player_Dead=1, the FSM SHALL stay in IDLE and issue no grants until Reset.
REQ-026 The tick counter SHALL clear on every state entry.

Reset
REQ-027 On Reset=1 at a Clk edge, the block SHALL enter IDLE and set ptr=0, Attack_Grant=0, Attack_Owner=0, Enemy_Attack_Ready=0, Player_HP=HP_INIT, tick counter=0, and clear the tick pipeline; Reset SHALL take priority over all events, including mid-SHOW or mid-COOLDOWN.

Configuration
REQ-028 Macro ENEMY_ATTACK_HEAL_EN: when defined, the block SHALL add input Heal (1 bit); each Clk cycle with Heal=1 SHALL add 8'd20 to Player_HP, saturating at HP_INIT.
REQ-029 With ENEMY_ATTACK_HEAL_EN defined and Heal coinciding with GRANT, the block SHALL apply HP-DAMAGE first, saturate at 0, then add the heal and saturate at HP_INIT; Heal SHALL have no effect when Player_Dead=1.
REQ-030 Without ENEMY_ATTACK_HEAL_EN, the Heal port SHALL not exist and HP SHALL only decrease.

Verification
REQ-031 Reset, Attack_Req=4'b0100, one frame_clk edge -> Attack_Grant=4'b0100 for 1 cycle, Attack_Owner=2, Player_HP=90, Enemy_Attack_Ready high for 4 ticks, low for 8 ticks.
REQ-032 Attack_Req=4'b1111 held over 4 attack cycles -> grants in order 0,1,2,3; Player_HP=60.
REQ-033 HP=5 (after 9 grants with DAMAGE=10 from 95, or via a parameter override), one more grant -> Player_HP=0, Player_Dead=1, no further grants with requests held.
REQ-034 Reset asserted on the 2nd SHOW tick -> next cycle IDLE, Enemy_Attack_Ready=0, Player_HP=100, ptr=0.
REQ-035 Attack_Req deasserted during COOLDOWN then reasserted -> no grant before COOLDOWN_FRAMES ticks elapse; grant on the first IDLE tick after.
REQ-036 With ENEMY_ATTACK_HEAL_EN defined, Player_HP=95 and Heal pulsed in the GRANT cycle -> Player_HP=100 (95-10+20 saturated at HP_INIT).

Source files
------------

// File: rtl/enemy_attack_scheduler.sv
// Enemy attack arbiter: round-robin grant per frame, show/cooldown pacing, HP.
// Optional ENEMY_ATTACK_HEAL_EN adds a Heal input (+20 HP per cycle, capped).
module enemy_attack_scheduler #(
  parameter int         NUM_ENEMY       = 4,
  parameter int         SHOW_FRAMES     = 4,
  parameter int         COOLDOWN_FRAMES = 8,
  parameter logic [7:0] DAMAGE          = 8'd10,
  parameter logic [7:0] HP_INIT         = 8'd100
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [NUM_ENEMY-1:0] Attack_Req,
`ifdef ENEMY_ATTACK_HEAL_EN
  input  logic                 Heal,
`endif
  output logic [NUM_ENEMY-1:0] Attack_Grant,
  output logic [2:0]           Attack_Owner,
  output logic                 Enemy_Attack_Ready,
  output logic [7:0]           Player_HP,
  output logic                 Player_Dead
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SHOW,
    COOLDOWN
  } state_t;

  localparam logic [7:0] SHOW_LAST = 8'(SHOW_FRAMES - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [2:0] LAST_IDX  = 3'(NUM_ENEMY - 1);

  state_t               state;
  logic [2:0]           ptr;
  logic [2:0]           winner;
  logic [7:0]           cnt;
  logic                 frame_d;
  logic                 tick;
  logic [2:0]           win;
  logic [2:0]           hi_idx;
  logic [2:0]           lo_idx;
  logic                 hi_found;
  logic [NUM_ENEMY-1:0] gvec;
  logic [7:0]           hp_dmg;
  logic [7:0]           hp_next;
`ifdef ENEMY_ATTACK_HEAL_EN
  logic [8:0]           hp_sum;
`endif

  assign Player_Dead = (Player_HP == 8'd0);

  // Lowest request at or above ptr wins; else wrap to lowest overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = NUM_ENEMY - 1; i >= 0; i--) begin
      if (Attack_Req[i]) begin
        lo_idx = 3'(i);
        if (3'(i) >= ptr) begin
          hi_idx   = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    gvec = '0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      if (3'(i) == win) gvec[i] = 1'b1;
    end
  end

  // Damage saturates at 0 first; heal then saturates at HP_INIT.
  always_comb begin
    hp_dmg  = (Player_HP > DAMAGE) ? Player_HP - DAMAGE : 8'd0;
    hp_next = (state == GRANT) ? hp_dmg : Player_HP;
`ifdef ENEMY_ATTACK_HEAL_EN
    hp_sum = {1'b0, hp_next} + 9'd20;
    if (Heal && !Player_Dead) begin
      hp_next = (hp_sum > {1'b0, HP_INIT}) ? HP_INIT : hp_sum[7:0];
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state              <= IDLE;
      ptr                <= '0;
      winner             <= '0;
      cnt                <= '0;
      frame_d            <= 1'b0;
      tick               <= 1'b0;
      Attack_Grant       <= '0;
      Attack_Owner       <= '0;
      Enemy_Attack_Ready <= 1'b0;
      Player_HP          <= HP_INIT;
    end else begin
      frame_d   <= frame_clk;
      tick      <= frame_clk & ~frame_d;
      Player_HP <= hp_next;
      unique case (state)
        IDLE: begin
          if (tick && (|Attack_Req) && !Player_Dead) begin
            winner       <= win;
            Attack_Grant <= gvec;
            cnt          <= '0;
            state        <= GRANT;
          end
        end
        GRANT: begin
          Attack_Grant       <= '0;
          Attack_Owner       <= winner;
          ptr                <= (winner == LAST_IDX) ? 3'd0 : winner + 3'd1;
          Enemy_Attack_Ready <= 1'b1;
          cnt                <= '0;
          state              <= SHOW;
        end
        SHOW: begin
          if (tick) begin
            if (cnt == SHOW_LAST) begin
              Enemy_Attack_Ready <= 1'b0;
              cnt                <= '0;
              state              <= COOLDOWN;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cnt == COOL_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_attack_scheduler.sv
// Directed bench for enemy_attack_scheduler (main and fast low-HP instance).
// Heal checks are compiled in when ENEMY_ATTACK_HEAL_EN is defined.
module tb_enemy_attack_scheduler;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [3:0] Attack_Req = '0;
  logic       Heal = 1'b0;
  logic [3:0] grant, grant2;
  logic [2:0] owner, owner2;
  logic       ready, ready2;
  logic [7:0] hp, hp2;
  logic       dead, dead2;

  int         gcnt = 0;
  int         g2cnt = 0;
  logic [3:0] last_grant = '0;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 Clk = ~Clk;

  enemy_attack_scheduler dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .frame_clk          (frame_clk),
    .Attack_Req         (Attack_Req),
`ifdef ENEMY_ATTACK_HEAL_EN
    .Heal               (Heal),
`endif
    .Attack_Grant       (grant),
    .Attack_Owner       (owner),
    .Enemy_Attack_Ready (ready),
    .Player_HP          (hp),
    .Player_Dead        (dead)
  );

  enemy_attack_scheduler #(
    .SHOW_FRAMES     (1),
    .COOLDOWN_FRAMES (1),
    .HP_INIT         (8'd25)
  ) dut2 (
    .Clk                (Clk),
    .Reset              (Reset),
    .frame_clk          (frame_clk),
    .Attack_Req         (Attack_Req),
`ifdef ENEMY_ATTACK_HEAL_EN
    .Heal               (1'b0),
`endif
    .Attack_Grant       (grant2),
    .Attack_Owner       (owner2),
    .Enemy_Attack_Ready (ready2),
    .Player_HP          (hp2),
    .Player_Dead        (dead2)
  );

  always @(negedge Clk) begin
    if (Reset) begin
      gcnt  <= 0;
      g2cnt <= 0;
    end else begin
      if (|grant) begin
        gcnt       <= gcnt + 1;
        last_grant <= grant;
      end
      if (|grant2) g2cnt <= g2cnt + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(3);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    frame_clk = 1'b0;
    step(2);
    Reset = 1'b0;
    step(1);
  endtask

  initial begin
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ready", ready, 0);
    chk("rst_hp", hp, 100);
    chk("rst_dead", dead, 0);

    Attack_Req = 4'b0100;
    frame();
    chk("g1_count", gcnt, 1);
    chk("g1_vec", last_grant, 4'b0100);
    chk("g1_owner", owner, 2);
    chk("g1_hp", hp, 90);
    chk("show_start", ready, 1);
    frames(3);
    chk("show_held", ready, 1);
    frame();
    chk("show_end", ready, 0);

    Attack_Req = 4'b0000;
    frames(7);
    Attack_Req = 4'b0100;
    frame();
    chk("cool_nogrant", gcnt, 1);
    frame();
    chk("after_cool", gcnt, 2);
    chk("after_cool_hp", hp, 80);

    frame();
    frame_clk = 1'b1;
    step(1);
    Reset     = 1'b1;
    frame_clk = 1'b0;
    step(1);
    Reset = 1'b0;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_hp", hp, 100);
    chk("mid_rst_owner", owner, 0);
    step(3);

    Attack_Req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      frame();
      chk($sformatf("rr_%0d", k), last_grant, 1 << k);
      frames(12);
    end
    chk("rr_hp", hp, 60);
    chk("sat_hp", hp2, 0);
    chk("sat_dead", dead2, 1);
    chk("sat_grants", g2cnt, 3);

    frames(6 * 13);
    chk("dead_hp", hp, 0);
    chk("dead_flag", dead, 1);
    chk("dead_grants", gcnt, 10);
    frames(13);
    chk("dead_nogrant", gcnt, 10);

`ifdef ENEMY_ATTACK_HEAL_EN
    do_reset();
    Attack_Req = 4'b0001;
    Heal = 1'b1;
    frame();
    Heal = 1'b0;
    chk("heal_grant", gcnt, 1);
    chk("heal_grant_hp", hp, 100);
    frames(12);
    frames(26);
    chk("heal_pre_hp", hp, 80);
    Heal = 1'b1;
    step(1);
    Heal = 1'b0;
    chk("heal_sat_hp", hp, 100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
